hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Pipeline control source for the deep-pipeline core. Drives the stall/flush inputs of
//   IF/ID, ID/EX and EX/MEM, plus the PC write enable.
//   Resolves hazards in priority order: data-memory wait, taken branch, multi-cycle EX op,
//   load-use. Also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
// PARAMETERS
//   REG_AW       5    register-address width
//   MC_LATENCY   4    total stall cycles per multi-cycle EX op (>=2)
//   MEM_TIMEOUT  64   consecutive mem_busy cycles before mem_timeout sets
//   PERF_W       16   stall_cycles counter width
// PORTS
//   clk            in   1        clock
//   reset          in   1        asynchronous, active-high reset
//   id_rs, id_rt   in   REG_AW   source registers of instruction in ID
//   id_uses_rs     in   1        ID instruction reads rs
//   id_uses_rt     in   1        ID instruction reads rt
//   ex_mem_read    in   1        instruction in EX is a load
//   ex_rd          in   REG_AW   destination register of instruction in EX
//   branch_taken   in   1        taken branch/jump resolved in EX this cycle
//   ex_mc_start    in   1        one-cycle pulse: multi-cycle op entered EX
//   mem_busy       in   1        data memory not ready; freeze pipeline
//   pc_write_en    out  1        PC may update
//   if_id_stall    out  1        hold IF/ID
//   if_id_flush    out  1        clear IF/ID
//   id_ex_stall    out  1        hold ID/EX
//   id_ex_flush    out  1        clear ID/EX (bubble)
//   ex_mem_stall   out  1        hold EX/MEM
//   ex_mem_flush   out  1        clear EX/MEM (bubble)
//   stall_cycles   out  PERF_W   count of cycles with pc_write_en==0; saturates at all-ones
//   mem_timeout    out  1        sticky; set after MEM_TIMEOUT consecutive mem_busy cycles
// BEHAVIOUR
//   Registered state:
//     - FSM RUN / MC_WAIT
//     - mc_cnt (MC_LATENCY-1 down-count)
//     - busy_cnt, stall_cycles, mem_timeout
//   Control outputs are combinational from state and inputs. Zero latency: same cycle as the hazard.
//   Reset: while reset=1, all control outputs are 0, including pc_write_en.
//     Registers clear: RUN, mc_cnt=0, busy_cnt=0, stall_cycles=0, mem_timeout=0.
//     Reset mid-MC_WAIT abandons the op.
//   Load-use hazard: ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
//   Priority, first match wins:
//   P1 mem_busy=1:
//      pc_write_en=0, all three stalls=1, all flushes=0.
//      FSM and mc_cnt frozen; ex_mc_start ignored.
//   P2 branch_taken=1 (state RUN):
//      pc_write_en=1, if_id_flush=1, id_ex_flush=1; load-use is cancelled.
//      branch_taken in MC_WAIT is a protocol violation and is ignored.
//   P3 MC stall (RUN & ex_mc_start, or state MC_WAIT):
//      pc_write_en=0, if_id_stall=1, id_ex_stall=1, ex_mem_flush=1.
//   P4 load-use (RUN):
//      pc_write_en=0, if_id_stall=1, id_ex_flush=1.
//   P5 otherwise: pc_write_en=1, all stalls and flushes 0.
//   FSM (ignores mem_busy cycles):
//     - RUN & ex_mc_start -> MC_WAIT, mc_cnt<=MC_LATENCY-1.
//     - MC_WAIT: mc_cnt decrements; at mc_cnt==1 -> RUN.
//     - Total stalled cycles = MC_LATENCY, plus any mem_busy cycles in between.
//     - ex_mc_start in MC_WAIT is ignored.
//   busy_cnt:
//     - Increments while mem_busy=1, saturates at MEM_TIMEOUT; clears when mem_busy=0.
//     - mem_timeout sets on the edge where busy_cnt reaches MEM_TIMEOUT.
//     - mem_timeout clears only on reset.
//   stall_cycles increments on each edge where pc_write_en==0 and reset=0; no wrap.
// TESTING
//   T1 Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1.
//      -> one cycle of pc_write_en=0, if_id_stall=1, id_ex_flush=1; stall_cycles=1.
//      Repeat with ex_rd=0 -> no stall.
//   T2 Branch + load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_write_en=1, no stall.
//   T3 ex_mc_start pulse, MC_LATENCY=4 -> exactly 4 cycles of stall with ex_mem_flush=1, then RUN.
//      With mem_busy=1 for 2 cycles mid-wait -> 6 stalled cycles total.
//   T4 mem_busy=1 for 64 cycles -> mem_timeout=1 after the 64th edge and stays 1 after mem_busy drops.
//      63 cycles -> stays 0.
//   T5 Reset asserted mid-MC_WAIT -> all outputs 0 immediately.
//      After release: RUN, pc_write_en=1, stall_cycles=0.
//   T6 Force PERF_W=4 with a long stall -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard controller. Produces the stall and flush controls for IF/ID,
//   ID/EX and EX/MEM, and the PC write enable. Hazards are resolved in this
//   priority order: data-memory wait, taken branch, multi-cycle EX op, load-use.
//   The block also keeps a saturating stall-cycle counter and a sticky
//   memory-timeout flag.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   id_rs, id_rt        source registers of the instruction in ID
//   id_uses_rs/rt       the ID instruction actually reads that source
//   ex_mem_read, ex_rd  the EX instruction is a load, and its destination register
//   branch_taken        a taken branch or jump resolved in EX
//   ex_mc_start         one-cycle pulse: a multi-cycle op entered EX
//   mem_busy            data memory not ready; the whole pipe freezes
//   pc_write_en         the PC may update
//   *_stall / *_flush   hold or clear the IF/ID, ID/EX and EX/MEM registers
//   stall_cycles        number of cycles with pc_write_en==0; saturates
//   mem_timeout         sticky; set after MEM_TIMEOUT consecutive busy cycles
module hazard_stall_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MC_LATENCY  = 4,
   parameter int MEM_TIMEOUT = 64,
   parameter int PERF_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              branch_taken,
   input  logic              ex_mc_start,
   input  logic              mem_busy,
   output logic              pc_write_en,
   output logic              if_id_stall,
   output logic              if_id_flush,
   output logic              id_ex_stall,
   output logic              id_ex_flush,
   output logic              ex_mem_stall,
   output logic              ex_mem_flush,
   output logic [PERF_W-1:0] stall_cycles,
   output logic              mem_timeout
);

   localparam int MCW = $clog2(MC_LATENCY + 1);
   localparam int BW  = $clog2(MEM_TIMEOUT + 1);

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_MC_WAIT = 1'b1;

   logic [0:0]     state, state_nxt;
   logic [MCW-1:0] mc_cnt, mc_cnt_nxt;
   logic [BW-1:0]  busy_cnt;
   logic           load_use;
   logic           in_run;

   assign in_run = (state == ST_RUN);

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) ||
                      (id_uses_rt && (id_rt == ex_rd)));

   // Control outputs. Everything, including pc_write_en, is held low while
   // reset is asserted, so the gating is done here rather than through state.
   always_comb begin
      pc_write_en  = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      ex_mem_flush = 1'b0;
      if (!reset) begin
         if (mem_busy) begin
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
         end else if (in_run && branch_taken) begin
            // The flush already removes the dependent instruction, so a
            // simultaneous load-use hazard needs no stall.
            pc_write_en = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (!in_run || ex_mc_start) begin
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (load_use) begin
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end else begin
            pc_write_en = 1'b1;
         end
      end
   end

   // The cycle in which ex_mc_start is seen already counts as the first stall
   // cycle. The counter therefore loads MC_LATENCY-1, and the FSM leaves
   // MC_WAIT on the edge where the counter is 1. Memory-busy cycles freeze
   // the FSM, so they extend the wait without consuming it.
   always_comb begin
      state_nxt  = state;
      mc_cnt_nxt = mc_cnt;
      if (!mem_busy) begin
         case (state)
            ST_RUN: if (ex_mc_start) begin
               state_nxt  = ST_MC_WAIT;
               mc_cnt_nxt = MCW'(MC_LATENCY - 1);
            end
            default: if (mc_cnt == MCW'(1)) begin
               state_nxt  = ST_RUN;
               mc_cnt_nxt = '0;
            end else begin
               mc_cnt_nxt = mc_cnt - MCW'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_RUN;
         mc_cnt <= '0;
      end else begin
         state  <= state_nxt;
         mc_cnt <= mc_cnt_nxt;
      end
   end

   // Consecutive-busy tracker. The flag sets on the edge where the count
   // reaches MEM_TIMEOUT, and stays set until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (mem_busy) begin
         if (busy_cnt != BW'(MEM_TIMEOUT))
            busy_cnt <= busy_cnt + BW'(1);
         if (busy_cnt == BW'(MEM_TIMEOUT - 1))
            mem_timeout <= 1'b1;
      end else begin
         busy_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cycles <= '0;
      else if (!pc_write_en && (stall_cycles != '1))
         stall_cycles <= stall_cycles + PERF_W'(1);
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Each stimulus cycle queues its expected
// controls, stall count and timeout flag. A negedge monitor pops the queue and
// compares. A second instance built with PERF_W=4 checks counter saturation.
module tb_hazard_stall_ctrl;

   localparam logic [6:0] P5 = 7'b1000000;  // {pc,ifs,iff,ids,idf,exs,exf}
   localparam logic [6:0] P1 = 7'b0101010;  // mem_busy freeze
   localparam logic [6:0] P2 = 7'b1010100;  // branch flush
   localparam logic [6:0] P3 = 7'b0101001;  // multi-cycle stall
   localparam logic [6:0] P4 = 7'b0100100;  // load-use bubble
   localparam logic [6:0] RZ = 7'b0000000;  // in reset

   typedef struct packed {
      logic [6:0]  ctrl;
      logic [15:0] sc;
      logic        tmo;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0;
   logic branch_taken = 0, ex_mc_start = 0, mem_busy = 0;

   logic pc_write_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic ex_mem_stall, ex_mem_flush, mem_timeout;
   logic [15:0] stall_cycles;

   logic s_pc, s_ifs, s_iff, s_ids, s_idf, s_exs, s_exf, s_tmo;
   logic [3:0] s_sc;

   exp_t q[$];
   int   exp_sc = 0;
   logic exp_tmo = 1'b0;
   int   busy_run = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .ex_mc_start(ex_mc_start), .mem_busy(mem_busy),
      .pc_write_en(pc_write_en), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
      .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
   );

   hazard_stall_ctrl #(.PERF_W(4)) dut4 (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .ex_mc_start(ex_mc_start), .mem_busy(mem_busy),
      .pc_write_en(s_pc), .if_id_stall(s_ifs), .if_id_flush(s_iff),
      .id_ex_stall(s_ids), .id_ex_flush(s_idf),
      .ex_mem_stall(s_exs), .ex_mem_flush(s_exf),
      .stall_cycles(s_sc), .mem_timeout(s_tmo)
   );

   // One stimulus cycle. The queued stall count is the value visible during
   // this cycle, before this cycle's own stall is counted.
   task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic mrd, input logic [4:0] rd,
                      input logic br, input logic mc, input logic busy,
                      input logic [6:0] ctrl);
      @(posedge clk); #1;
      reset = 1'b0;
      id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      ex_mem_read = mrd; ex_rd = rd; branch_taken = br; ex_mc_start = mc; mem_busy = busy;
      q.push_back('{ctrl: ctrl, sc: 16'(exp_sc), tmo: exp_tmo});
      if (!ctrl[6]) exp_sc++;
      if (busy) begin
         busy_run++;
         if (busy_run >= 64) exp_tmo = 1'b1;
      end else begin
         busy_run = 0;
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, P5);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset = 1'b1;
         q.push_back('{ctrl: RZ, sc: 16'd0, tmo: 1'b0});
         exp_sc = 0; exp_tmo = 1'b0; busy_run = 0;
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [6:0] got;
         logic [3:0] sat;
         e = q.pop_front();
         vectors++;
         got = {pc_write_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, ex_mem_flush};
         sat = (e.sc > 16'd15) ? 4'd15 : e.sc[3:0];
         if (got !== e.ctrl) begin
            miscompares++;
            $display("FAIL ctrl vec %0d: got %b want %b", vectors, got, e.ctrl);
         end
         if (stall_cycles !== e.sc) begin
            miscompares++;
            $display("FAIL stall_cycles vec %0d: got %0d want %0d", vectors, stall_cycles, e.sc);
         end
         if (mem_timeout !== e.tmo) begin
            miscompares++;
            $display("FAIL mem_timeout vec %0d: got %b want %b", vectors, mem_timeout, e.tmo);
         end
         if (s_sc !== sat) begin
            miscompares++;
            $display("FAIL stall_cycles_w4 vec %0d: got %0d want %0d", vectors, s_sc, sat);
         end
      end
   end

   initial begin
      do_reset(2);
      idle();                                  // out of reset: RUN, count 0
      // Load-use hazards and their non-hazard variants
      cyc(8, 0, 1, 0, 1, 8, 0, 0, 0, P4);      // rs match
      idle();                                  // count now 1
      cyc(0, 0, 1, 0, 1, 0, 0, 0, 0, P5);      // ex_rd == 0
      cyc(0, 9, 0, 1, 1, 9, 0, 0, 0, P4);      // rt match
      cyc(8, 0, 0, 0, 1, 8, 0, 0, 0, P5);      // rs not used
      cyc(8, 0, 1, 0, 0, 8, 0, 0, 0, P5);      // not a load
      // Branch cancels a load-use hazard in the same cycle
      cyc(8, 0, 1, 0, 1, 8, 1, 0, 0, P2);
      // Multi-cycle op: 4 stall cycles; hazards and repeat starts during the wait are ignored
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, P3);
      cyc(8, 0, 1, 0, 1, 8, 0, 0, 0, P3);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, P3);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, P3);
      idle();
      // Multi-cycle op with 2 busy cycles in the middle: 6 stalled cycles
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, P3);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, P3);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, P1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, P1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, P3);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, P3);
      idle();
      // A start that arrives during a busy cycle is dropped
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, P1);
      idle();
      // 63 busy cycles do not time out; 64 do, and the flag is sticky
      for (int i = 0; i < 63; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, P1);
      idle();
      for (int i = 0; i < 64; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, P1);
      idle();
      idle();
      // Reset in the middle of a multi-cycle wait
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, P3);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, P3);
      do_reset(1);
      idle();
      idle();
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
